// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and helpers for the three-floor elevator
//               controller: floor index type, FSM state and travel direction
//               enums, and "calls beyond this floor" helpers used for SCAN.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // True when any latched call sits strictly above floor f.
    function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p, input floor_t f);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && p[i]) found = 1'b1;
        end
        return found;
    endfunction

    // True when any latched call sits strictly below floor f.
    function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p, input floor_t f);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && p[i]) found = 1'b1;
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : elev_timer
// Description : Loadable down-counter with zero / last-count flags. Load has
//               priority over decrement. Used for both travel and door timing.
// Revision    : 1.0 - initial release
// ============================================================================
module elev_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero,
    output logic             last
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count register: load wins, otherwise decrement when enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign zero = (r_count == '0);
    assign last = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl
// Description : Three-floor elevator controller with SCAN direction choice,
//               latched calls, travel and door timers. Optional emergency
//               stop input is compiled in with `define ELEVATOR_ESTOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] call,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  moving,
    output logic                  door_open,
    output floor_t                cur_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int c_TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int c_DOOR_W   = $clog2(DOOR_CYCLES + 1);
    localparam logic [c_TRAVEL_W-1:0] c_TRAVEL_LOAD = c_TRAVEL_W'(TRAVEL_CYCLES);
    localparam logic [c_DOOR_W-1:0]   c_DOOR_LOAD   = c_DOOR_W'(DOOR_CYCLES);

    state_t                r_state;
    dir_t                  r_dir;
    floor_t                r_floor;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_motor_up, r_motor_down, r_moving, r_door_open;

    logic                  w_run;
    logic                  w_is_move;
    floor_t                w_next_floor;
    logic                  w_idle_serve, w_idle_start, w_start_up;
    logic                  w_arrive, w_arrive_stop, w_arrive_cont;
    logic                  w_door_reload, w_door_done;
    logic                  w_travel_load, w_travel_en, w_travel_zero, w_travel_last;
    logic                  w_door_load, w_door_en, w_door_zero, w_door_last;
    logic [NUM_FLOORS-1:0] w_call_eff, w_clear, w_pending_next;

`ifdef ELEVATOR_ESTOP_EN
    assign w_run = ~estop;
`else
    assign w_run = 1'b1;
`endif

    // Decision terms shared by the FSM, the timers and the call latch.
    always_comb begin
        w_is_move     = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
        w_next_floor  = (r_state == ST_MOVE_UP) ? (r_floor + 2'd1) : (r_floor - 2'd1);

        w_idle_serve  = w_run && (r_state == ST_IDLE) && r_pending[r_floor];
        w_idle_start  = w_run && (r_state == ST_IDLE) && !r_pending[r_floor] && (|r_pending);
        // SCAN: keep heading while work lies ahead, otherwise turn around.
        w_start_up    = (r_dir == DIR_UP) ? calls_above(r_pending, r_floor)
                                          : !calls_below(r_pending, r_floor);

        w_arrive      = w_run && w_is_move && w_travel_last;
        w_arrive_stop = w_arrive && r_pending[w_next_floor];
        w_arrive_cont = w_arrive && !r_pending[w_next_floor] &&
                        ((r_state == ST_MOVE_UP) ? calls_above(r_pending, w_next_floor)
                                                 : calls_below(r_pending, w_next_floor));

        w_door_reload = w_run && (r_state == ST_DOOR) && call[r_floor];
        w_door_done   = w_run && (r_state == ST_DOOR) && w_door_last && !w_door_reload;

        w_travel_load = w_idle_start || w_arrive_cont;
        w_travel_en   = w_run && w_is_move && !w_travel_zero;
        w_door_load   = w_idle_serve || w_arrive_stop || w_door_reload;
        w_door_en     = w_run && (r_state == ST_DOOR) && !w_door_zero;

        // A call at the floor whose door is open is already being served.
        w_call_eff = call;
        if (r_state == ST_DOOR) w_call_eff[r_floor] = 1'b0;

        w_clear = '0;
        if (w_idle_serve)  w_clear[r_floor]      = 1'b1;
        if (w_arrive_stop) w_clear[w_next_floor] = 1'b1;

        w_pending_next = (r_pending | w_call_eff) & ~w_clear;
    end

    elev_timer #(.WIDTH(c_TRAVEL_W)) u_travel_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_travel_load),
        .load_val (c_TRAVEL_LOAD),
        .en       (w_travel_en),
        .zero     (w_travel_zero),
        .last     (w_travel_last)
    );

    elev_timer #(.WIDTH(c_DOOR_W)) u_door_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_door_load),
        .load_val (c_DOOR_LOAD),
        .en       (w_door_en),
        .zero     (w_door_zero),
        .last     (w_door_last)
    );

    // Controller FSM with registered motor/door outputs and the call latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_UP;
            r_floor      <= '0;
            r_pending    <= '0;
            r_motor_up   <= 1'b0;
            r_motor_down <= 1'b0;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (!w_run) begin
                r_motor_up   <= 1'b0;
                r_motor_down <= 1'b0;
                r_moving     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_idle_serve) begin
                            r_state     <= ST_DOOR;
                            r_door_open <= 1'b1;
                        end else if (w_idle_start) begin
                            r_dir        <= w_start_up ? DIR_UP : DIR_DOWN;
                            r_state      <= w_start_up ? ST_MOVE_UP : ST_MOVE_DOWN;
                            r_motor_up   <= w_start_up;
                            r_motor_down <= !w_start_up;
                            r_moving     <= 1'b1;
                        end
                    end
                    ST_MOVE_UP, ST_MOVE_DOWN: begin
                        r_motor_up   <= (r_state == ST_MOVE_UP);
                        r_motor_down <= (r_state == ST_MOVE_DOWN);
                        r_moving     <= 1'b1;
                        if (w_arrive) begin
                            r_floor <= w_next_floor;
                            if (w_arrive_stop || !w_arrive_cont) begin
                                r_state      <= w_arrive_stop ? ST_DOOR : ST_IDLE;
                                r_door_open  <= w_arrive_stop;
                                r_motor_up   <= 1'b0;
                                r_motor_down <= 1'b0;
                                r_moving     <= 1'b0;
                            end
                        end
                    end
                    ST_DOOR: begin
                        if (w_door_done) begin
                            r_state     <= ST_IDLE;
                            r_door_open <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign motor_up   = r_motor_up;
    assign motor_down = r_motor_down;
    assign moving     = r_moving;
    assign door_open  = r_door_open;
    assign cur_floor  = r_floor;
    assign pending    = r_pending;

endmodule
`default_nettype wire
